// File: rtl/cklnq_hyst_gate_array.sv
`default_nettype none
// ============================================================================
// Module   : cklnq_hyst_gate_array
// Brief    : Multi-channel negedge-latched clock gate with idle hysteresis,
//            reset/test override and saturating gated-cycle counters.
// Revision : 1.0 - initial release
// ============================================================================
module cklnq_hyst_gate_array #(
    parameter int NUM_CH = 4,
    parameter int HOLD_W = 4,
    parameter int CNT_W  = 16
) (
    input  logic                    CP,
    input  logic                    RST,
    input  logic                    TE,
    input  logic [NUM_CH-1:0]       E,
    input  logic [HOLD_W-1:0]       HOLD_CNT,
    input  logic                    CLR,
    output logic [NUM_CH-1:0]       Q,
    output logic [NUM_CH-1:0]       ON,
    output logic [NUM_CH-1:0]       DRAIN,
    output logic [NUM_CH*CNT_W-1:0] GATED_CNT
);

    localparam logic [CNT_W-1:0]  c_cnt_max  = '1;
    localparam logic [CNT_W-1:0]  c_cnt_one  = CNT_W'(1);
    localparam logic [HOLD_W-1:0] c_hold_one = HOLD_W'(1);

    // Keeps every clock alive through the edge that first samples RST low,
    // so downstream synchronous resets get an edge on which to leave reset.
    logic r_rst_d;

    always_ff @(posedge CP) begin
        r_rst_d <= RST;
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            logic [HOLD_W-1:0] r_hold;
            logic [CNT_W-1:0]  r_cnt;
            logic              r_qd;
            logic              w_hold_nz;
            logic              w_en;

            assign w_hold_nz = |r_hold;
            assign w_en      = TE | RST | r_rst_d | E[gi] | w_hold_nz;

            // A live request reloads the tail; HOLD_CNT is ignored while draining.
            always_ff @(posedge CP) begin
                if (RST) begin
                    r_hold <= '0;
                end else if (E[gi]) begin
                    r_hold <= HOLD_CNT;
                end else if (w_hold_nz) begin
                    r_hold <= r_hold - c_hold_one;
                end
            end

            always_ff @(negedge CP) begin
                r_qd <= w_en;
            end

            always_ff @(posedge CP) begin
                if (RST || CLR) begin
                    r_cnt <= '0;
                end else if (!r_qd && (r_cnt != c_cnt_max)) begin
                    r_cnt <= r_cnt + c_cnt_one;
                end
            end

            assign Q[gi]                          = CP & r_qd;
            assign ON[gi]                         = r_qd;
            assign DRAIN[gi]                      = ~E[gi] & w_hold_nz;
            assign GATED_CNT[gi*CNT_W +: CNT_W]   = r_cnt;
        end
    endgenerate

endmodule
`default_nettype wire
